pim_dma_ctrl: RTL and testbench
===============================

Name: pim_dma_ctrl

Overview:
- Responder end of the core's DMA command interface.
- Captures a one-cycle DMA command pulse from the core's EX stage, raises busy, and moves 32-bit words between data memory and the selected PIM unit's local buffer.
- Masters the data-memory port through a req/gnt handshake and drives a simple one-cycle-latency PIM buffer port.

Parameters:
- XLEN, 32, data/address width.
- NUM_PIM, 4, number of PIM units; width of the one-hot select.
- PIM_AW, 11, PIM buffer word-address width (covers 13-bit byte size).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- dma_en_i  in  1  command pulse from core
- dma_funct3_i  in  3  3'b000 = MEM->PIM, 3'b001 = PIM->MEM; other values are not commands
- dma_sel_pim_i  in  NUM_PIM  one-hot PIM select
- dma_size_i  in  13  transfer size in bytes
- dma_mem_addr_i  in  XLEN  memory start byte address
- dma_busy_o  out  1  engine active
- mem_req_o  out  1  memory port request
- mem_gnt_i  in  1  memory port grant
- mem_addr_o  out  XLEN  word address
- mem_wr_data_o  out  XLEN  store data
- mem_rd_data_i  in  XLEN  load data, valid the cycle after a granted read
- mem_size_o  out  4  byte enables
- mem_read_o  out  1  read strobe
- mem_write_o  out  1  write strobe
- pim_sel_o  out  NUM_PIM  PIM select
- pim_addr_o  out  PIM_AW  buffer word index
- pim_wr_data_o  out  XLEN  buffer write data
- pim_we_o  out  1  buffer write
- pim_re_o  out  1  buffer read; data valid next cycle

Behaviour:
- Reset (async, rst_i=1):
  - State goes to IDLE.
  - Every output and every internal register is 0.
  - Reset asserted mid-transfer aborts the transfer immediately; there is no resume.
- Command capture:
  - In IDLE, dma_en_i=1 with funct3 000 or 001 latches funct3, sel, addr, and words = size[12:2].
  - Address is latched with bits [1:0] forced to 0. size[1:0] is ignored.
  - dma_en_i with any other funct3 is ignored, and the block stays IDLE.
  - dma_en_i outside IDLE is ignored.
- dma_busy_o = (state != IDLE), driven combinationally from the state register. It is high from the cycle after the pulse through the DONE cycle.
- States: IDLE, MRD, PWR, PRD, PLAT, MWR, DONE.
- IDLE exits:
  - Goes to MRD for MEM->PIM, or PRD for PIM->MEM.
  - Goes to DONE directly if words == 0.
- MEM->PIM path:
  - MRD: mem_req_o=1, mem_read_o=1, mem_size_o=4'b1111, mem_addr_o = base + 4*idx. Holds until mem_gnt_i=1, then goes to PWR.
  - PWR: pim_we_o=1, pim_addr_o=idx, pim_wr_data_o = mem_rd_data_i.
  - After PWR: if idx == words-1, go to DONE; otherwise idx++ and return to MRD.
- PIM->MEM path:
  - PRD: pim_re_o=1, pim_addr_o=idx, then goes to PLAT.
  - PLAT: wbuf <= pim_rd_data_i, then goes to MWR.
  - MWR: mem_req_o=1, mem_write_o=1, mem_size_o=4'b1111, mem_addr_o = base + 4*idx, mem_wr_data_o = wbuf. Holds until mem_gnt_i, then goes to DONE or back to PRD using the same idx rule.
- Request hold: while mem_gnt_i is low, all memory outputs and wbuf stay stable.
- DONE: one cycle, then IDLE; idx clears to 0.
- pim_sel_o = latched sel whenever state != IDLE, else 0. A zero sel still runs the full sequence.
- Memory outputs: mem_req_o, mem_read_o, mem_write_o and mem_size_o are 0 outside MRD/MWR. mem_wr_data_o is 0 outside MWR.
- Address arithmetic is modulo 2^XLEN, so memory addresses wrap from 0xFFFF_FFFC to 0.
- Throughput with an immediate grant: 2 cycles/word for MEM->PIM, 3 cycles/word for PIM->MEM.
- Maximum transfer is 2047 words (size 13'h1FFC), so idx stays within PIM_AW bits.

Test Plan:
- Reset → all outputs 0. Then pulse en, funct3=000, sel=4'b0010, size=16, addr=0x2000_0003 with grant tied high → mem reads at 0x2000_0000, 0x2000_0004, 0x2000_0008, 0x2000_000C; pim writes to idx 0..3 with the returned data; busy high for exactly 9 cycles.
- PIM->MEM: funct3=001, size=8, addr=0x100, PIM returns 0xA5A5_0000 then 0x5A5A_0001 → mem writes 0x100=0xA5A5_0000 and 0x104=0x5A5A_0001; busy high for 7 cycles.
- Grant stall: during MWR hold mem_gnt_i low for 3 cycles → req, addr and data stay stable; the write completes on the grant cycle; total busy time grows by 3.
- size=3 (words 0) or funct3=3'b010 → size=3 gives a 1-cycle busy (DONE only) with no memory or PIM strobes; funct3=010 never asserts busy.
- Assert rst_i mid-transfer during MRD → next edge shows busy=0, req=0, pim_sel_o=0. A new command after reset starts from idx 0.
- Address wrap: addr=0xFFFF_FFF8, size=16, MEM->PIM → reads at 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.

Source files
------------

// File: rtl/pim_dma_ctrl.sv
// Responder end of the core's DMA command interface: moves 32-bit words between
// data memory (req/gnt port) and one PIM unit's local buffer (1-cycle read latency).
module pim_dma_ctrl #(
  parameter int XLEN    = 32,
  parameter int NUM_PIM = 4,
  parameter int PIM_AW  = 11
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               dma_en_i,
  input  logic [2:0]         dma_funct3_i,
  input  logic [NUM_PIM-1:0] dma_sel_pim_i,
  input  logic [12:0]        dma_size_i,
  input  logic [XLEN-1:0]    dma_mem_addr_i,
  output logic               dma_busy_o,
  output logic               mem_req_o,
  input  logic               mem_gnt_i,
  output logic [XLEN-1:0]    mem_addr_o,
  output logic [XLEN-1:0]    mem_wr_data_o,
  input  logic [XLEN-1:0]    mem_rd_data_i,
  output logic [3:0]         mem_size_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [NUM_PIM-1:0] pim_sel_o,
  output logic [PIM_AW-1:0]  pim_addr_o,
  output logic [XLEN-1:0]    pim_wr_data_o,
  input  logic [XLEN-1:0]    pim_rd_data_i,
  output logic               pim_we_o,
  output logic               pim_re_o
);

  typedef enum logic [2:0] {IDLE, MRD, PWR, PRD, PLAT, MWR, DONE} state_e;

  state_e             state_q, state_d;
  logic [NUM_PIM-1:0] sel_q;
  logic [XLEN-1:0]    base_q, wbuf_q, cur_addr;
  logic [10:0]        words_q;
  logic [PIM_AW-1:0]  idx_q;
  logic               dir_q, cmd_ok, last;

  // Sub-word parts of size/address are dropped by design.
  logic unused_bits;
  assign unused_bits = ^{dma_size_i[1:0], dma_mem_addr_i[1:0]};

  assign cmd_ok   = dma_en_i && (dma_funct3_i == 3'b000 || dma_funct3_i == 3'b001);
  assign last     = (idx_q == PIM_AW'(words_q - 11'd1));
  assign cur_addr = base_q + XLEN'({idx_q, 2'b00});

  assign dma_busy_o = (state_q != IDLE);
  assign pim_sel_o  = (state_q != IDLE) ? sel_q : '0;

  always_comb begin
    state_d       = state_q;
    mem_req_o     = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    mem_size_o    = 4'b0000;
    mem_addr_o    = '0;
    mem_wr_data_o = '0;
    pim_we_o      = 1'b0;
    pim_re_o      = 1'b0;
    pim_addr_o    = '0;
    pim_wr_data_o = '0;
    case (state_q)
      IDLE: if (cmd_ok) begin
        if (dma_size_i[12:2] == 11'd0) state_d = DONE;
        else                           state_d = dma_funct3_i[0] ? PRD : MRD;
      end
      MRD: begin
        mem_req_o  = 1'b1;
        mem_read_o = 1'b1;
        mem_size_o = 4'b1111;
        mem_addr_o = cur_addr;
        if (mem_gnt_i) state_d = PWR;
      end
      PWR: begin
        pim_we_o      = 1'b1;
        pim_addr_o    = idx_q;
        pim_wr_data_o = mem_rd_data_i;
        state_d       = last ? DONE : MRD;
      end
      PRD: begin
        pim_re_o   = 1'b1;
        pim_addr_o = idx_q;
        state_d    = PLAT;
      end
      PLAT: state_d = MWR;
      MWR: begin
        mem_req_o     = 1'b1;
        mem_write_o   = 1'b1;
        mem_size_o    = 4'b1111;
        mem_addr_o    = cur_addr;
        mem_wr_data_o = wbuf_q;
        if (mem_gnt_i) state_d = last ? DONE : PRD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      base_q  <= '0;
      wbuf_q  <= '0;
      words_q <= '0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (cmd_ok) begin
          dir_q   <= dma_funct3_i[0];
          sel_q   <= dma_sel_pim_i;
          base_q  <= {dma_mem_addr_i[XLEN-1:2], 2'b00};
          words_q <= dma_size_i[12:2];
        end
        PWR:  if (!last) idx_q <= idx_q + 1'b1;
        PLAT: wbuf_q <= pim_rd_data_i;
        MWR:  if (mem_gnt_i && !last) idx_q <= idx_q + 1'b1;
        DONE: idx_q <= '0;
        default: ;
      endcase
    end
  end

  // Direction is folded into the IDLE exit; kept for debug visibility.
  logic unused_dir;
  assign unused_dir = dir_q;

endmodule

// File: tb/tb_pim_dma_ctrl.sv
// Directed bench for pim_dma_ctrl with a simple memory and PIM buffer model.
module tb_pim_dma_ctrl;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        dma_en_i = 1'b0;
  logic [2:0]  dma_funct3_i = '0;
  logic [3:0]  dma_sel_pim_i = '0;
  logic [12:0] dma_size_i = '0;
  logic [31:0] dma_mem_addr_i = '0;
  logic        dma_busy_o, mem_req_o, mem_gnt_i = 1'b1;
  logic [31:0] mem_addr_o, mem_wr_data_o, mem_rd_data_i = '0;
  logic [3:0]  mem_size_o;
  logic        mem_read_o, mem_write_o;
  logic [3:0]  pim_sel_o;
  logic [10:0] pim_addr_o;
  logic [31:0] pim_wr_data_o, pim_rd_data_i = '0;
  logic        pim_we_o, pim_re_o;

  int vec = 0, err = 0;

  pim_dma_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .dma_en_i(dma_en_i), .dma_funct3_i(dma_funct3_i),
    .dma_sel_pim_i(dma_sel_pim_i), .dma_size_i(dma_size_i), .dma_mem_addr_i(dma_mem_addr_i),
    .dma_busy_o(dma_busy_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_wr_data_o(mem_wr_data_o), .mem_rd_data_i(mem_rd_data_i),
    .mem_size_o(mem_size_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .pim_sel_o(pim_sel_o), .pim_addr_o(pim_addr_o), .pim_wr_data_o(pim_wr_data_o),
    .pim_rd_data_i(pim_rd_data_i), .pim_we_o(pim_we_o), .pim_re_o(pim_re_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory returns {C0DE, addr[15:0]} the cycle after a granted read; PIM buffer has 1-cycle latency.
  logic [31:0] pim_mem [0:7];
  always @(posedge clk_i) begin
    if (mem_req_o && mem_gnt_i && mem_read_o) mem_rd_data_i <= {16'hC0DE, mem_addr_o[15:0]};
    if (pim_re_o) pim_rd_data_i <= pim_mem[pim_addr_o[2:0]];
  end

  logic [31:0] rd_q[$], wr_a_q[$], wr_d_q[$], pw_d_q[$];
  logic [10:0] pw_i_q[$];
  logic [3:0]  pw_s_q[$];
  int busy_cnt = 0, strobe_cnt = 0;

  always @(negedge clk_i) begin
    if (mem_req_o && mem_gnt_i && mem_read_o) rd_q.push_back(mem_addr_o);
    if (mem_req_o && mem_gnt_i && mem_write_o) begin
      wr_a_q.push_back(mem_addr_o); wr_d_q.push_back(mem_wr_data_o);
    end
    if (pim_we_o) begin
      pw_i_q.push_back(pim_addr_o); pw_d_q.push_back(pim_wr_data_o); pw_s_q.push_back(pim_sel_o);
    end
    if (dma_busy_o) busy_cnt++;
    if (mem_req_o || mem_read_o || mem_write_o || pim_we_o || pim_re_o) strobe_cnt++;
  end

  task automatic clear_logs();
    rd_q.delete(); wr_a_q.delete(); wr_d_q.delete();
    pw_i_q.delete(); pw_d_q.delete(); pw_s_q.delete();
    busy_cnt = 0; strobe_cnt = 0;
  endtask

  task automatic pulse(input logic [2:0] f3, input logic [3:0] sel,
                       input logic [12:0] size, input logic [31:0] addr);
    @(posedge clk_i); #1;
    dma_en_i = 1'b1; dma_funct3_i = f3; dma_sel_pim_i = sel;
    dma_size_i = size; dma_mem_addr_i = addr;
    @(posedge clk_i); #1;
    dma_en_i = 1'b0; dma_funct3_i = '0; dma_sel_pim_i = '0; dma_size_i = '0; dma_mem_addr_i = '0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (dma_busy_o && n < 200) begin @(negedge clk_i); n++; end
    @(negedge clk_i);
    vec++;
    if (dma_busy_o !== 1'b0) begin
      err++; $display("FAIL %s timeout: busy=%b expected 0", name, dma_busy_o);
    end
  endtask

  task automatic test_reset();
    #2;
    vec++;
    if ({dma_busy_o, mem_req_o, mem_addr_o, mem_wr_data_o, mem_size_o, mem_read_o, mem_write_o,
         pim_sel_o, pim_addr_o, pim_wr_data_o, pim_we_o, pim_re_o} !== '0) begin
      err++; $display("FAIL reset_outputs: some output nonzero (busy=%b req=%b) expected all 0",
                      dma_busy_o, mem_req_o);
    end
    @(posedge clk_i); #1 rst_i = 1'b0;
  endtask

  task automatic test_mem2pim();
    logic [31:0] exp_a [4] = '{32'h2000_0000, 32'h2000_0004, 32'h2000_0008, 32'h2000_000C};
    clear_logs(); mem_gnt_i = 1'b1;
    pulse(3'b000, 4'b0010, 13'd16, 32'h2000_0003);
    wait_idle("m2p");
    vec++;
    if (rd_q.size() != 4 || pw_i_q.size() != 4) begin
      err++; $display("FAIL m2p_count: reads=%0d pimwr=%0d expected 4/4", rd_q.size(), pw_i_q.size());
    end else for (int i = 0; i < 4; i++) begin
      vec++;
      if (rd_q[i] !== exp_a[i] || pw_i_q[i] !== 11'(i) ||
          pw_d_q[i] !== {16'hC0DE, exp_a[i][15:0]} || pw_s_q[i] !== 4'b0010) begin
        err++; $display("FAIL m2p_word%0d: rd=%h idx=%0d data=%h sel=%b expected %h %0d %h 0010",
                        i, rd_q[i], pw_i_q[i], pw_d_q[i], pw_s_q[i], exp_a[i], i, {16'hC0DE, exp_a[i][15:0]});
      end
    end
    vec++;
    if (busy_cnt != 9) begin err++; $display("FAIL m2p_busy: got %0d expected 9", busy_cnt); end
  endtask

  task automatic test_pim2mem();
    clear_logs(); mem_gnt_i = 1'b1;
    pim_mem[0] = 32'hA5A5_0000; pim_mem[1] = 32'h5A5A_0001;
    pulse(3'b001, 4'b0001, 13'd8, 32'h0000_0100);
    wait_idle("p2m");
    vec++;
    if (wr_a_q.size() != 2) begin
      err++; $display("FAIL p2m_count: writes=%0d expected 2", wr_a_q.size());
    end else begin
      vec++;
      if (wr_a_q[0] !== 32'h100 || wr_d_q[0] !== 32'hA5A5_0000) begin
        err++; $display("FAIL p2m_w0: %h=%h expected 00000100=a5a50000", wr_a_q[0], wr_d_q[0]);
      end
      vec++;
      if (wr_a_q[1] !== 32'h104 || wr_d_q[1] !== 32'h5A5A_0001) begin
        err++; $display("FAIL p2m_w1: %h=%h expected 00000104=5a5a0001", wr_a_q[1], wr_d_q[1]);
      end
    end
    vec++;
    if (busy_cnt != 7) begin err++; $display("FAIL p2m_busy: got %0d expected 7", busy_cnt); end
  endtask

  task automatic test_stall();
    int n = 0;
    clear_logs(); pim_mem[0] = 32'h1234_5678;
    mem_gnt_i = 1'b0;
    pulse(3'b001, 4'b1000, 13'd4, 32'h0000_0040);
    while (!mem_write_o && n < 20) begin @(negedge clk_i); n++; end
    for (int c = 0; c < 3; c++) begin
      vec++;
      if (mem_req_o !== 1'b1 || mem_write_o !== 1'b1 || mem_addr_o !== 32'h40 ||
          mem_wr_data_o !== 32'h1234_5678 || mem_size_o !== 4'b1111) begin
        err++; $display("FAIL stall_hold%0d: req=%b wr=%b addr=%h data=%h expected 1 1 00000040 12345678",
                        c, mem_req_o, mem_write_o, mem_addr_o, mem_wr_data_o);
      end
      if (c < 2) @(negedge clk_i);
    end
    @(posedge clk_i); #1 mem_gnt_i = 1'b1;
    wait_idle("stall");
    vec++;
    if (wr_a_q.size() != 1 || wr_a_q[0] !== 32'h40 || wr_d_q[0] !== 32'h1234_5678) begin
      err++; $display("FAIL stall_write: count=%0d expected one write 00000040=12345678", wr_a_q.size());
    end
    vec++;
    if (busy_cnt != 7) begin err++; $display("FAIL stall_busy: got %0d expected 7", busy_cnt); end
  endtask

  task automatic test_zero_and_illegal();
    clear_logs();
    pulse(3'b000, 4'b0100, 13'd3, 32'h0000_0800);
    wait_idle("zero");
    vec++;
    if (busy_cnt != 1 || strobe_cnt != 0) begin
      err++; $display("FAIL zero_words: busy=%0d strobes=%0d expected 1/0", busy_cnt, strobe_cnt);
    end
    clear_logs();
    pulse(3'b010, 4'b0100, 13'd16, 32'h0000_0800);
    repeat (5) @(negedge clk_i);
    vec++;
    if (busy_cnt != 0 || strobe_cnt != 0) begin
      err++; $display("FAIL bad_funct3: busy=%0d strobes=%0d expected 0/0", busy_cnt, strobe_cnt);
    end
  endtask

  task automatic test_reset_mid();
    mem_gnt_i = 1'b0;
    pulse(3'b000, 4'b0010, 13'd16, 32'h0000_0300);
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
    vec++;
    if (dma_busy_o !== 1'b0 || mem_req_o !== 1'b0 || pim_sel_o !== 4'b0000) begin
      err++; $display("FAIL mid_reset: busy=%b req=%b sel=%b expected 0 0 0000", dma_busy_o, mem_req_o, pim_sel_o);
    end
    rst_i = 1'b0; mem_gnt_i = 1'b1;
    clear_logs();
    pulse(3'b000, 4'b0001, 13'd8, 32'h0000_0500);
    wait_idle("post_rst");
    vec++;
    if (rd_q.size() != 2 || pw_i_q.size() != 2) begin
      err++; $display("FAIL post_rst_count: reads=%0d pimwr=%0d expected 2/2", rd_q.size(), pw_i_q.size());
    end else begin
      vec++;
      if (rd_q[0] !== 32'h500 || rd_q[1] !== 32'h504 || pw_i_q[0] !== 11'd0 || pw_i_q[1] !== 11'd1) begin
        err++; $display("FAIL post_rst_seq: rd=%h,%h idx=%0d,%0d expected 00000500,00000504 0,1",
                        rd_q[0], rd_q[1], pw_i_q[0], pw_i_q[1]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    clear_logs(); mem_gnt_i = 1'b1;
    pulse(3'b000, 4'b0100, 13'd16, 32'hFFFF_FFF8);
    wait_idle("wrap");
    vec++;
    if (rd_q.size() != 4) begin
      err++; $display("FAIL wrap_count: reads=%0d expected 4", rd_q.size());
    end else for (int i = 0; i < 4; i++) begin
      vec++;
      if (rd_q[i] !== exp_a[i]) begin
        err++; $display("FAIL wrap_addr%0d: got %h expected %h", i, rd_q[i], exp_a[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) pim_mem[i] = '0;
    test_reset();
    test_mem2pim();
    test_pim2mem();
    test_stall();
    test_zero_and_illegal();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
